// File: rtl/rsp_dma_seq.sv
// rsp_dma_seq: beat sequencer for DMA transfers between DBUS and IMEM/DMEM.
// Accepts one transfer descriptor in IDLE, arbitrates for the bus, issues one
// 64-bit beat per granted cycle, drains the 3-stage read pipeline, then
// pulses done. All outputs come straight from flops.
// Optional abort support is compiled in with the macro RSP_DMA_ABORT_EN.
module rsp_dma_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_imem,
  input  logic       cfg_dir,
  input  logic [11:3] cfg_addr,
  input  logic [8:0] cfg_len,
  input  logic [1:0] cfg_first_mask,
  input  logic [1:0] cfg_last_mask,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [11:3] dma_address,
  output logic [1:0] dma_mask,
  output logic       dma_rd_to_dm,
  output logic       dma_dm_to_rd,
  output logic       dma_imem_select,
`ifdef RSP_DMA_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_issue;
  logic        w_accept;
  logic        w_abort;

  logic [8:0]  r_addr;
  logic [8:0]  r_cnt;
  logic [1:0]  r_first_mask;
  logic [1:0]  r_last_mask;
  logic        r_dir;
  logic        r_first;
  logic        r_last;
  logic [1:0]  r_drain;
  logic        r_abort;

  // Word mask of the beat about to be issued; a single-beat transfer merges both masks.
  function automatic logic [1:0] beat_mask(input logic first, input logic last,
                                           input logic [1:0] fm, input logic [1:0] lm);
    logic [1:0] m;
    m = 2'b11;
    if (first) m = m & fm;
    if (last)  m = m & lm;
    return m;
  endfunction

  assign w_accept = (r_state == S_IDLE) && cfg_valid;

`ifdef RSP_DMA_ABORT_EN
  assign w_abort = abort && ((r_state == S_ARB) || (r_state == S_XFER));
`else
  assign w_abort = 1'b0;
`endif

  // Next-state decode and beat-issue decision.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE:  if (cfg_valid) w_next = S_ARB;
      S_ARB: begin
        if (w_abort) begin
          w_next = S_DRAIN;
        end else if (bus_gnt) begin
          w_next  = S_XFER;
          w_issue = 1'b1;
        end
      end
      S_XFER: begin
        // The beat presented this cycle is complete; decide whether another follows.
        if (w_abort || r_last) begin
          w_next = S_DRAIN;
        end else if (bus_gnt) begin
          w_issue = 1'b1;
        end else begin
          w_next = S_ARB;
        end
      end
      S_DRAIN: if (r_drain == 2'd2) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and sequencing flags (first/last beat, drain count, abort record).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_drain <= 2'd0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (w_accept) begin
        r_first <= 1'b1;
        r_last  <= 1'b0;
        r_abort <= 1'b0;
      end else begin
        if (w_issue) begin
          r_first <= 1'b0;
          r_last  <= (r_cnt == 9'd0);
        end
        if (w_abort) r_abort <= 1'b1;
      end
    end
  end

  // Descriptor capture and next-beat address/counter; held across grant stalls.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr       <= cfg_addr;
      r_cnt        <= cfg_len;
      r_first_mask <= cfg_first_mask;
      r_last_mask  <= cfg_last_mask;
      r_dir        <= cfg_dir;
    end else if (w_issue) begin
      r_addr <= r_addr + 9'd1;
      r_cnt  <= r_cnt - 9'd1;
    end
  end

  // Registered outputs, computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready       <= 1'b1;
      busy            <= 1'b0;
      bus_req         <= 1'b0;
      done            <= 1'b0;
      dma_rd_to_dm    <= 1'b0;
      dma_dm_to_rd    <= 1'b0;
      dma_address     <= 9'd0;
      dma_mask        <= 2'b00;
      dma_imem_select <= 1'b0;
    end else begin
      cfg_ready    <= (w_next == S_IDLE);
      busy         <= (w_next != S_IDLE);
      bus_req      <= (w_next == S_ARB) || (w_next == S_XFER);
      done         <= (w_next == S_DONE);
      dma_rd_to_dm <= w_issue && !r_dir;
      dma_dm_to_rd <= w_issue && r_dir;
      if (w_issue) begin
        dma_address <= r_addr;
        dma_mask    <= beat_mask(r_first, (r_cnt == 9'd0), r_first_mask, r_last_mask);
      end
      if (w_accept) dma_imem_select <= cfg_imem;
    end
  end

`ifdef RSP_DMA_ABORT_EN
  // Abort indication accompanies the done pulse of an abandoned transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= (w_next == S_DONE) && (r_abort || w_abort);
  end
`endif

endmodule

// File: tb/tb_rsp_dma_seq.sv
// Directed self-checking bench for rsp_dma_seq.
module tb_rsp_dma_seq;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_imem;
  logic       cfg_dir;
  logic [8:0] cfg_addr;
  logic [8:0] cfg_len;
  logic [1:0] cfg_first_mask;
  logic [1:0] cfg_last_mask;
  logic       bus_req;
  logic       bus_gnt;
  logic [8:0] dma_address;
  logic [1:0] dma_mask;
  logic       dma_rd_to_dm;
  logic       dma_dm_to_rd;
  logic       dma_imem_select;
  logic       busy;
  logic       done;
`ifdef RSP_DMA_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks;
  int errors;

  // Results captured by run()
  int         nbeats;
  logic [8:0] baddr [0:15];
  logic [1:0] bmask [0:15];
  int         last_cyc;
  int         done_cyc;
  int         bad_dir;
  int         bad_imem;
  logic       req_drain;
  logic       ab_seen;

  rsp_dma_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_imem(cfg_imem),
    .cfg_dir(cfg_dir),
    .cfg_addr(cfg_addr),
    .cfg_len(cfg_len),
    .cfg_first_mask(cfg_first_mask),
    .cfg_last_mask(cfg_last_mask),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .dma_address(dma_address),
    .dma_mask(dma_mask),
    .dma_rd_to_dm(dma_rd_to_dm),
    .dma_dm_to_rd(dma_dm_to_rd),
    .dma_imem_select(dma_imem_select),
`ifdef RSP_DMA_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one transfer and observe it until done (bounded). Beat numbers are 1-based.
  task automatic run(input logic imem, input logic dir, input logic [8:0] addr,
                     input logic [8:0] len, input logic [1:0] fm, input logic [1:0] lm,
                     input int stall_at, input int stall_len, input int abort_at,
                     input int poke_at);
    int cyc;
    int stall_left;
    logic stalled;
    logic beat;
    nbeats = 0; last_cyc = -1; done_cyc = -1; bad_dir = 0; bad_imem = 0;
    req_drain = 1'b1; ab_seen = 1'b0; stall_left = 0; stalled = 1'b0;
    cfg_imem = imem; cfg_dir = dir; cfg_addr = addr; cfg_len = len;
    cfg_first_mask = fm; cfg_last_mask = lm; cfg_valid = 1'b1; bus_gnt = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_addr  = 9'h0AA;
    cfg_len   = 9'h1FF;
    cyc = 1;
    chk("arb_req", 32'(bus_req), 1);
    chk("arb_strobes", 32'({dma_rd_to_dm, dma_dm_to_rd}), 0);
    chk("arb_ready", 32'(cfg_ready), 0);
    while (done_cyc < 0 && cyc < 200) begin
      tick();
      cyc++;
`ifdef RSP_DMA_ABORT_EN
      abort = 1'b0;
`endif
      cfg_valid = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus_gnt = 1'b1;
      end
      beat = dma_rd_to_dm | dma_dm_to_rd;
      if (beat) begin
        if (nbeats < 16) begin
          baddr[nbeats] = dma_address;
          bmask[nbeats] = dma_mask;
        end
        if ((dma_rd_to_dm && dma_dm_to_rd) || (dma_dm_to_rd != dir)) bad_dir++;
        if (dma_imem_select != imem) bad_imem++;
        nbeats++;
        last_cyc = cyc;
        if (stall_at == nbeats && !stalled) begin
          bus_gnt = 1'b0;
          stall_left = stall_len;
          stalled = 1'b1;
        end
`ifdef RSP_DMA_ABORT_EN
        if (abort_at == nbeats) abort = 1'b1;
`endif
        if (poke_at == nbeats) begin
          cfg_valid = 1'b1;
          cfg_addr  = 9'h055;
        end
      end
      if (last_cyc > 0 && cyc == last_cyc + 1) req_drain = bus_req;
      if (done) begin
        done_cyc = cyc;
`ifdef RSP_DMA_ABORT_EN
        ab_seen = aborted;
`endif
      end
    end
    chk("done_seen", 32'(done_cyc >= 0), 1);
    chk("dir_strobes", bad_dir, 0);
    chk("imem_select", bad_imem, 0);
    chk("req_drops_in_drain", 32'(req_drain), 0);
    if (abort_at == 0 && done_cyc >= 0) chk("done_gap", done_cyc - last_cyc, 4);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_imem = 1'b0; cfg_dir = 1'b0;
    cfg_addr = 9'h0; cfg_len = 9'h0; cfg_first_mask = 2'b00; cfg_last_mask = 2'b00;
    bus_gnt = 1'b0;
`ifdef RSP_DMA_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    // Reset state
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_addr", 32'(dma_address), 0);
    chk("rst_mask", 32'(dma_mask), 0);
    chk("rst_strobes", 32'({dma_rd_to_dm, dma_dm_to_rd, dma_imem_select, done}), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cfg_ready), 1);

    // Basic write, with a request poked mid-transfer that must be ignored
    run(1'b0, 1'b0, 9'h010, 9'd3, 2'b01, 2'b10, 0, 0, 0, 1);
    chk("w_nbeats", nbeats, 4);
    chk("w_a0", 32'(baddr[0]), 32'h010);
    chk("w_a1", 32'(baddr[1]), 32'h011);
    chk("w_a2", 32'(baddr[2]), 32'h012);
    chk("w_a3", 32'(baddr[3]), 32'h013);
    chk("w_masks", 32'({bmask[0], bmask[1], bmask[2], bmask[3]}), 32'b01_11_11_10);
    chk("w_last_cyc", last_cyc, 5);
    chk("w_done_cyc", done_cyc, 9);
    chk("w_done_busy", 32'(busy), 1);
    tick();
    chk("w_idle_ready", 32'(cfg_ready), 1);
    chk("w_idle_done", 32'({busy, done}), 0);
    tick();
    chk("w_poke_ignored", 32'({bus_req, busy}), 0);

    // Single beat read
    run(1'b0, 1'b1, 9'h100, 9'd0, 2'b11, 2'b01, 0, 0, 0, 0);
    chk("s_nbeats", nbeats, 1);
    chk("s_addr", 32'(baddr[0]), 32'h100);
    chk("s_mask", 32'(bmask[0]), 32'b01);
    chk("s_done_cyc", done_cyc, 6);
    tick();

    // Grant stall of two cycles after the 2nd beat
    run(1'b0, 1'b0, 9'h020, 9'd4, 2'b10, 2'b01, 2, 2, 0, 0);
    chk("g_nbeats", nbeats, 5);
    chk("g_a0", 32'(baddr[0]), 32'h020);
    chk("g_a1", 32'(baddr[1]), 32'h021);
    chk("g_a2", 32'(baddr[2]), 32'h022);
    chk("g_a3", 32'(baddr[3]), 32'h023);
    chk("g_a4", 32'(baddr[4]), 32'h024);
    chk("g_masks", 32'({bmask[0], bmask[1], bmask[2], bmask[3], bmask[4]}), 32'b10_11_11_11_01);
    chk("g_done_cyc", done_cyc, 12);
    tick();

    // Address wrap, IMEM read
    run(1'b1, 1'b1, 9'h1FE, 9'd2, 2'b11, 2'b11, 0, 0, 0, 0);
    chk("r_nbeats", nbeats, 3);
    chk("r_a0", 32'(baddr[0]), 32'h1FE);
    chk("r_a1", 32'(baddr[1]), 32'h1FF);
    chk("r_a2", 32'(baddr[2]), 32'h000);
    chk("r_imem_sel", 32'(dma_imem_select), 1);
    tick();

    // Reset asserted during the 3rd beat
    cfg_imem = 1'b0; cfg_dir = 1'b0; cfg_addr = 9'h080; cfg_len = 9'd5;
    cfg_first_mask = 2'b11; cfg_last_mask = 2'b11; bus_gnt = 1'b1; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("x_beat3_addr", 32'(dma_address), 32'h082);
    chk("x_beat3_strobe", 32'(dma_rd_to_dm), 1);
    rst_n = 1'b0;
    #1;
    chk("x_async_req", 32'(bus_req), 0);
    chk("x_async_strobes", 32'({dma_rd_to_dm, dma_dm_to_rd}), 0);
    chk("x_async_state", 32'({cfg_ready, busy, done}), 32'b100);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("x_no_done", 32'({done, busy, bus_req}), 0);
    end
    run(1'b0, 1'b0, 9'h0C0, 9'd1, 2'b10, 2'b11, 0, 0, 0, 0);
    chk("x_new_nbeats", nbeats, 2);
    chk("x_new_a0", 32'(baddr[0]), 32'h0C0);
    chk("x_new_a1", 32'(baddr[1]), 32'h0C1);
    chk("x_new_masks", 32'({bmask[0], bmask[1]}), 32'b10_11);
    tick();

`ifdef RSP_DMA_ABORT_EN
    // Abort during the 2nd beat of an 8-beat transfer
    run(1'b0, 1'b0, 9'h040, 9'd7, 2'b11, 2'b11, 0, 0, 2, 0);
    chk("a_nbeats", nbeats, 2);
    chk("a_done_gap", done_cyc - last_cyc, 4);
    chk("a_aborted", 32'(ab_seen), 1);
    tick();
    chk("a_idle", 32'({aborted, done, busy}), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsp_dma_seq.md
RSP_DMA_SEQ -- requirements
Module: rsp_dma_seq

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst_n`: input, 1 bit, reset that is asynchronous and active-low.
REQ-003 The block SHALL have the port `cfg_valid`: input, 1 bit, transfer request qualifier.
REQ-004 The block SHALL have the port `cfg_ready`: output, 1 bit, high only in IDLE; a request is accepted when `cfg_valid` and `cfg_ready` are both high in the same cycle.
REQ-005 The block SHALL have the port `cfg_imem`: input, 1 bit; 1 targets IMEM, 0 targets DMEM.
REQ-006 The block SHALL have the port `cfg_dir`: input, 1 bit; 0 = DBUS to memory (write), 1 = memory to DBUS (read).
REQ-007 The block SHALL have the port `cfg_addr`: input, [11:3], start beat address.
REQ-008 The block SHALL have the port `cfg_len`: input, 9 bits, beat count minus 1.
REQ-009 The block SHALL have the port `cfg_first_mask`: input, 2 bits, word mask of the first beat ([1] = upper word [63:32]).
REQ-010 The block SHALL have the port `cfg_last_mask`: input, 2 bits, word mask of the last beat.
REQ-011 The block SHALL have the port `bus_req`: output, 1 bit, DBUS ownership request.
REQ-012 The block SHALL have the port `bus_gnt`: input, 1 bit, DBUS grant from the external arbiter.
REQ-013 The block SHALL have the port `dma_address`: output, [11:3], current beat address.
REQ-014 The block SHALL have the port `dma_mask`: output, 2 bits, current beat word mask.
REQ-015 The block SHALL have the port `dma_rd_to_dm`: output, 1 bit, write-beat strobe.
REQ-016 The block SHALL have the port `dma_dm_to_rd`: output, 1 bit, read-beat strobe.
REQ-017 The block SHALL have the port `dma_imem_select`: output, 1 bit, registered copy of `cfg_imem`.
REQ-018 The block SHALL have the port `busy`: output, 1 bit, high in every state except IDLE.
REQ-019 The block SHALL have the port `done`: output, 1 bit, one-cycle pulse when a transfer completes.

Function
REQ-020 The state machine SHALL have exactly five states: IDLE, ARB, XFER, DRAIN and DONE.
REQ-021 On acceptance, the block SHALL capture all cfg_* inputs and go IDLE -> ARB on the next edge.
REQ-022 In ARB, `bus_req` SHALL be 1 and the beat strobes SHALL be 0; ARB SHALL go to XFER in the cycle after `bus_gnt` is sampled 1.
REQ-023 In XFER, while `bus_gnt` is 1, the block SHALL issue one beat per cycle: exactly one of `dma_rd_to_dm` / `dma_dm_to_rd` is asserted (per `cfg_dir`), and `bus_req` stays 1.
REQ-024 After each beat, `dma_address` SHALL increment by 1 and wrap 0x1FF -> 0x000 with no carry-out.
REQ-025 The beat counter SHALL be 9 bits, loaded with `cfg_len`, and decremented per beat; the beat issued with counter = 0 is the last beat.
REQ-026 `dma_mask` SHALL be `cfg_first_mask` on the first beat, `cfg_last_mask` on the last beat, and 2'b11 otherwise.
REQ-027 When `cfg_len` = 0, the single beat SHALL use `cfg_first_mask & cfg_last_mask`.
REQ-028 If `bus_gnt` is 0 in XFER, the block SHALL issue no beat that cycle and return to ARB with address, counter and first-beat flag held; it SHALL resume without skipping or repeating a beat.
REQ-029 After the last beat, the block SHALL go XFER -> DRAIN, drop `bus_req`, and hold there for exactly 3 cycles to cover the 3-stage read-data pipeline of the bus interface.
REQ-030 DRAIN SHALL be followed by DONE, which lasts 1 cycle with `done` = 1, then IDLE.
REQ-031 `cfg_valid` presented while `busy` = 1 SHALL be ignored, with no queueing.
REQ-032 A transfer SHALL take exactly len+1 beat cycles plus one ARB cycle plus 3 DRAIN cycles plus 1 DONE cycle, excluding grant stalls.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While `rst_n` = 0, the block SHALL be in IDLE with `cfg_ready` = 1 and all other outputs = 0, including `dma_address` = 0 and `dma_mask` = 2'b00.
REQ-035 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no `done` pulse, and deassert `bus_req` asynchronously.
REQ-036 Reset release SHALL take effect at the first clock edge after `rst_n` rises.

Configuration
REQ-037 With the macro `RSP_DMA_ABORT_EN` defined, the block SHALL add the input `abort` (1 bit).
REQ-038 `abort` = 1 in ARB or XFER SHALL stop beat issue the next cycle, drop `bus_req`, and enter DRAIN (full 3 cycles) then DONE.
REQ-039 An aborted transfer SHALL also raise the output `aborted` together with `done`.
REQ-040 `abort` SHALL be ignored in IDLE, DRAIN and DONE.
REQ-041 Without `RSP_DMA_ABORT_EN`, the `abort` and `aborted` ports SHALL be absent, and behaviour SHALL be as REQ-020..REQ-033.

Verification
REQ-042 Basic write: cfg_imem=0, cfg_dir=0, cfg_addr=0x010, cfg_len=3, masks 2'b01/2'b10, `bus_gnt` tied 1 -> `dma_rd_to_dm` high for 4 consecutive cycles, addresses 0x010..0x013, masks 01,11,11,10, `done` exactly 4 cycles after the last beat.
REQ-043 Single beat: cfg_len=0, masks 2'b11/2'b01 -> one beat with mask 2'b01.
REQ-044 Grant stall: `bus_gnt` dropped for 2 cycles after the 2nd beat of cfg_len=4 -> 5 beats total with contiguous addresses and no duplicate beat.
REQ-045 Wrap: cfg_addr=0x1FE, cfg_len=2, cfg_dir=1, cfg_imem=1 -> addresses 0x1FE, 0x1FF, 0x000 with `dma_dm_to_rd` and `dma_imem_select` = 1.
REQ-046 Reset mid-XFER: `rst_n` low during the 3rd beat -> `bus_req` and strobes drop at once, `done` never pulses, and a new request after release starts cleanly.
REQ-047 With `RSP_DMA_ABORT_EN`: `abort` pulsed during the 2nd beat of cfg_len=7 -> at most 2 beats issued, then DRAIN of 3 cycles, then `done` = 1 with `aborted` = 1.
